// File: rtl/cop0_regs.sv
// CP0 register file: exception/ERET commit, Status/Cause/EPC state, Count/Compare timer
// and the masked interrupt request, serving MFC0/MTC0 from the MEM stage.
module cop0_regs #(
    parameter int   COUNT_DIV = 2,
    parameter logic RST_BEV   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [4:0]  regAddr,
    input  logic        regWe,
    input  logic [31:0] regWData,
    output logic [31:0] regRData,
    input  logic        excAccept,
    input  logic        eret,
    input  logic [31:0] excEPC,
    input  logic        excBD,
    input  logic [4:0]  excCode,
    input  logic [31:0] badVAddrIn,
    input  logic        writeBadVAddr,
    input  logic [5:0]  hwInt,
    output logic [31:0] regEPCOut,
    output logic [31:0] regErrorEPCOut,
    output logic        statusEXL,
    output logic        statusBEV,
    output logic        statusERL,
    output logic        causeIV,
    output logic        interrupt
);

    localparam logic [31:0] STATUS_MASK = 32'h1040_FF17;
    localparam int          DIV_W       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [31:0]      status_q, status_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:0]      error_epc_q, error_epc_d;
    logic [31:0]      bad_vaddr_q, bad_vaddr_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             bd_q, bd_d;
    logic             ti_q, ti_d;
    logic             iv_q, iv_d;
    logic [1:0]       ip_sw_q, ip_sw_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic [5:0]       sync1_q, sync2_q;

    logic             mtc_en_s;
    logic             wr_count_s;
    logic             wr_compare_s;
    logic             div_wrap_s;
    logic [7:0]       ip_s;
    logic [31:0]      cause_s;

    assign ip_s    = {sync2_q[5] | ti_q, sync2_q[4:0], ip_sw_q};
    assign cause_s = {bd_q, ti_q, 6'd0, iv_q, 7'd0, ip_s, 1'b0, exc_code_q, 2'd0};

    // Next-state: timer runs every cycle, commits only when the pipeline is not stalled.
    always_comb begin
        status_d    = status_q;
        epc_d       = epc_q;
        error_epc_d = error_epc_q;
        bad_vaddr_d = bad_vaddr_q;
        count_d     = count_q;
        compare_d   = compare_q;
        div_d       = div_q;
        bd_d        = bd_q;
        ti_d        = ti_q;
        iv_d        = iv_q;
        ip_sw_d     = ip_sw_q;
        exc_code_d  = exc_code_q;

        mtc_en_s     = ~stall & ~excAccept & ~eret & regWe;
        wr_count_s   = mtc_en_s && (regAddr == 5'd9);
        wr_compare_s = mtc_en_s && (regAddr == 5'd11);
        div_wrap_s   = (div_q == DIV_LAST);

        if (wr_count_s) begin
            count_d = regWData;
            div_d   = '0;
        end else if (div_wrap_s) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d   = div_q + DIV_W'(1);
        end

        // TI is only raised by a real increment landing on Compare; a Compare write always wins.
        if (wr_compare_s) begin
            compare_d = regWData;
            ti_d      = 1'b0;
        end else if (!wr_count_s && div_wrap_s && ((count_q + 32'd1) == compare_q)) begin
            ti_d      = 1'b1;
        end else begin
            ti_d      = ti_q;
        end

        if (stall) begin
            status_d = status_q;
        end else if (excAccept) begin
            if (!status_q[1]) begin
                epc_d = excEPC;
                bd_d  = excBD;
            end else begin
                epc_d = epc_q;
            end
            status_d[1] = 1'b1;
            exc_code_d  = excCode;
            if (writeBadVAddr) begin
                bad_vaddr_d = badVAddrIn;
            end else begin
                bad_vaddr_d = bad_vaddr_q;
            end
        end else if (eret) begin
            if (status_q[2]) begin
                status_d[2] = 1'b0;
            end else begin
                status_d[1] = 1'b0;
            end
        end else if (regWe) begin
            case (regAddr)
                5'd12:   status_d    = regWData & STATUS_MASK;
                5'd13: begin
                    iv_d    = regWData[23];
                    ip_sw_d = regWData[9:8];
                end
                5'd14:   epc_d       = regWData;
                5'd30:   error_epc_d = regWData;
                default: status_d    = status_q;
            endcase
        end else begin
            status_d = status_q;
        end
    end

    // State registers, including the two-flop hwInt synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q    <= {9'd0, RST_BEV, 19'd0, 1'b1, 2'd0};
            epc_q       <= 32'd0;
            error_epc_q <= 32'd0;
            bad_vaddr_q <= 32'd0;
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            div_q       <= '0;
            bd_q        <= 1'b0;
            ti_q        <= 1'b0;
            iv_q        <= 1'b0;
            ip_sw_q     <= 2'd0;
            exc_code_q  <= 5'd0;
            sync1_q     <= 6'd0;
            sync2_q     <= 6'd0;
        end else begin
            status_q    <= status_d;
            epc_q       <= epc_d;
            error_epc_q <= error_epc_d;
            bad_vaddr_q <= bad_vaddr_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            div_q       <= div_d;
            bd_q        <= bd_d;
            ti_q        <= ti_d;
            iv_q        <= iv_d;
            ip_sw_q     <= ip_sw_d;
            exc_code_q  <= exc_code_d;
            sync1_q     <= hwInt;
            sync2_q     <= sync1_q;
        end
    end

    // MFC0 read mux; a same-cycle write is not yet visible here.
    always_comb begin
        case (regAddr)
            5'd8:    regRData = bad_vaddr_q;
            5'd9:    regRData = count_q;
            5'd11:   regRData = compare_q;
            5'd12:   regRData = status_q;
            5'd13:   regRData = cause_s;
            5'd14:   regRData = epc_q;
            5'd30:   regRData = error_epc_q;
            default: regRData = 32'd0;
        endcase
    end

    assign regEPCOut      = epc_q;
    assign regErrorEPCOut = error_epc_q;
    assign statusEXL      = status_q[1];
    assign statusBEV      = status_q[22];
    assign statusERL      = status_q[2];
    assign causeIV        = iv_q;
    assign interrupt      = status_q[0] & ~status_q[1] & ~status_q[2] & (|(status_q[15:8] & ip_s));

endmodule
